// File: rtl/pergate_addmul_seq_if.sv
// pergate_addmul_seq_if
//   Bundles the sequencer-side control (start/step plus their operands),
//   the multiplier-slice handshake and the status/result outputs of
//   pergate_addmul_seq. clk and rstb are not part of this interface.
//   slave  : view taken by pergate_addmul_seq
//   master : view taken by whoever drives the controller and models the
//            multiplier slice (sumcheck FSM + slice, or a bench)
//   Optional macro PERGATE_SEQ_ABORT_EN adds the abort input.
interface pergate_addmul_seq_if #(
  parameter int NGATEBITS = 3,
  parameter int F_NBITS   = 16
);
  // sumcheck control side
  logic                           start;
  logic [NGATEBITS-1:0]           gate_id;
  logic [NGATEBITS*F_NBITS-1:0]   taus;
  logic [NGATEBITS*F_NBITS-1:0]   m_taus_p1;
  logic                           step;
  logic                           step_bit;
  logic [F_NBITS-1:0]             step_tau;
  logic [F_NBITS-1:0]             step_m_tau_p1;
`ifdef PERGATE_SEQ_ABORT_EN
  logic                           abort;
`endif
  // multiplier slice side
  logic                           mult_en;
  logic                           mult_restart;
  logic                           mult_gate_bit;
  logic [F_NBITS-1:0]             mult_tau;
  logic [F_NBITS-1:0]             mult_m_tau_p1;
  logic                           mult_ready_pulse;
  logic [F_NBITS-1:0]             mult_result;
  // status
  logic                           busy;
  logic                           valid;
  logic                           done;
  logic [F_NBITS-1:0]             result;

  modport slave (
`ifdef PERGATE_SEQ_ABORT_EN
    input  abort,
`endif
    input  start, gate_id, taus, m_taus_p1,
    input  step, step_bit, step_tau, step_m_tau_p1,
    output mult_en, mult_restart, mult_gate_bit, mult_tau, mult_m_tau_p1,
    input  mult_ready_pulse, mult_result,
    output busy, valid, done, result
  );

  modport master (
`ifdef PERGATE_SEQ_ABORT_EN
    output abort,
`endif
    output start, gate_id, taus, m_taus_p1,
    output step, step_bit, step_tau, step_m_tau_p1,
    input  mult_en, mult_restart, mult_gate_bit, mult_tau, mult_m_tau_p1,
    output mult_ready_pulse, mult_result,
    input  busy, valid, done, result
  );
endinterface

// File: rtl/pergate_addmul_seq.sv
// pergate_addmul_seq
//   Controller for one per-gate add/mul multiplier slice. A start walks the
//   gate label bits g[0]..g[NGATEBITS-1], issuing one multiply per bit with
//   tau_k (bit=1) or (1 - tau_k) (bit=0); the first multiply restarts the
//   slice accumulator at 1. Once a product is valid, each step issues one
//   more multiply of the held product by r or (1 - r).
//
// Ports:
//   clk   : clock
//   rstb  : asynchronous active-low reset (also resets the multiplier slice)
//   bus   : pergate_addmul_seq_if.slave
//           start/gate_id/taus/m_taus_p1     initial-product request
//           step/step_bit/step_tau/step_m_tau_p1  single extra multiply
//           mult_*                           multiplier slice handshake
//           busy/valid/done/result           status and registered product
//
// Optional macro PERGATE_SEQ_ABORT_EN: adds bus.abort; abort in ISSUE/WAIT
//   drops back to IDLE with valid cleared, no done, result untouched.
module pergate_addmul_seq #(
  parameter int NGATEBITS = 3,
  parameter int F_NBITS   = 16
) (
  input  logic               clk,
  input  logic               rstb,
  pergate_addmul_seq_if.slave bus
);

  localparam int            KW     = (NGATEBITS > 1) ? $clog2(NGATEBITS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NGATEBITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]           state;
  logic [KW-1:0]        k;
  logic [NGATEBITS-1:0] gate_q;
  logic                 step_mode;

  // registered outputs
  logic                 en_q;
  logic                 restart_q;
  logic                 bit_q;
  logic [F_NBITS-1:0]   tau_q;
  logic [F_NBITS-1:0]   mtau_q;
  logic                 busy_q;
  logic                 valid_q;
  logic                 done_q;
  logic [F_NBITS-1:0]   result_q;

  logic                 abort_in;
`ifdef PERGATE_SEQ_ABORT_EN
  assign abort_in = bus.abort;
`else
  assign abort_in = 1'b0;
`endif

  // Operands for the next sequence-mode issue. Leaving IDLE issues bit 0
  // straight from the live gate_id; leaving WAIT issues bit k+1 from the
  // latched label. Operand registers are loaded on entry to ISSUE so they
  // sit stable for the whole ISSUE+WAIT window.
  logic [KW-1:0]        k_nxt;
  logic                 seq_bit;
  logic [F_NBITS-1:0]   seq_tau;
  logic [F_NBITS-1:0]   seq_mtau;

  always_comb begin
    k_nxt    = (state == S_WAIT) ? k + 1'b1 : '0;
    seq_bit  = (state == S_WAIT) ? gate_q[k_nxt] : bus.gate_id[0];
    seq_tau  = bus.taus[int'(k_nxt)*F_NBITS +: F_NBITS];
    seq_mtau = bus.m_taus_p1[int'(k_nxt)*F_NBITS +: F_NBITS];
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= S_IDLE;
      k         <= '0;
      gate_q    <= '0;
      step_mode <= 1'b0;
      en_q      <= 1'b0;
      restart_q <= 1'b0;
      bit_q     <= 1'b0;
      tau_q     <= '0;
      mtau_q    <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      // single-cycle strobes
      en_q      <= 1'b0;
      restart_q <= 1'b0;
      done_q    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            // new initial product: old result stays readable but is no
            // longer valid until this sequence finishes
            gate_q    <= bus.gate_id;
            k         <= '0;
            step_mode <= 1'b0;
            valid_q   <= 1'b0;
            en_q      <= 1'b1;
            restart_q <= 1'b1;
            bit_q     <= seq_bit;
            tau_q     <= seq_tau;
            mtau_q    <= seq_mtau;
            busy_q    <= 1'b1;
            state     <= S_ISSUE;
          end else if (bus.step && valid_q) begin
            // step multiplies the slice's held product, never restarts
            step_mode <= 1'b1;
            en_q      <= 1'b1;
            bit_q     <= bus.step_bit;
            tau_q     <= bus.step_tau;
            mtau_q    <= bus.step_m_tau_p1;
            busy_q    <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (abort_in) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= S_IDLE;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort_in) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= S_IDLE;
          end else if (bus.mult_ready_pulse) begin
            if (!step_mode && (k != K_LAST)) begin
              k      <= k_nxt;
              en_q   <= 1'b1;
              bit_q  <= seq_bit;
              tau_q  <= seq_tau;
              mtau_q <= seq_mtau;
              state  <= S_ISSUE;
            end else begin
              result_q <= bus.mult_result;
              done_q   <= 1'b1;
              valid_q  <= 1'b1;
              state    <= S_FIN;
            end
          end
        end
        default: begin // S_FIN
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mult_en       = en_q;
  assign bus.mult_restart  = restart_q;
  assign bus.mult_gate_bit = bit_q;
  assign bus.mult_tau      = tau_q;
  assign bus.mult_m_tau_p1 = mtau_q;
  assign bus.busy          = busy_q;
  assign bus.valid         = valid_q;
  assign bus.done          = done_q;
  assign bus.result        = result_q;

endmodule

// File: doc/pergate_addmul_seq.md
Name: pergate_addmul_seq

Overview:
- Controller for one per-gate add/mul multiplier slice (field_multiplier wrapped with restart/bit-select muxing).
- On start, walks the gate label bits g[0]..g[NGATEBITS-1]. Issues one multiply per bit, choosing tau_{k+1} or (1 - tau_{k+1}) per bit, to form the initial per-gate add_i/mul_i product.
- Afterwards, accepts single "step" multiplies as the verifier supplies further random elements during sumcheck.
- Sits between the per-level sumcheck control FSM and the pergate multiplier slice.

Parameters:
- NGATEBITS, 3, number of gate-label bits (lgG); legal range 1..32.

Ports:
- clk  input  1  clock
- rstb  input  1  asynchronous active-low reset
- start  input  1  pulse; begin initial product for gate_id
- gate_id  input  NGATEBITS  gate label; sampled on accepted start
- taus  input  NGATEBITS*F_NBITS  tau vector; element k at [k*F_NBITS +: F_NBITS]; held stable while busy
- m_taus_p1  input  NGATEBITS*F_NBITS  precomputed (1 - tau_k) mod p, same packing
- step  input  1  pulse; one extra multiply of current result
- step_bit  input  1  selects step_tau (1) or step_m_tau_p1 (0)
- step_tau  input  F_NBITS  verifier element r
- step_m_tau_p1  input  F_NBITS  (1 - r) mod p
- mult_en  output  1  enable pulse to multiplier slice
- mult_restart  output  1  multiplier a-operand = 1 instead of fed-back product
- mult_gate_bit  output  1  multiplier tau-select
- mult_tau  output  F_NBITS  tau operand
- mult_m_tau_p1  output  F_NBITS  1-tau operand
- mult_ready_pulse  input  1  multiplier completion pulse
- mult_result  input  F_NBITS  multiplier output
- busy  output  1  sequence in progress
- valid  output  1  result holds a completed product
- done  output  1  one-cycle pulse on completion of start sequence or step
- result  output  F_NBITS  registered copy of the latest product

Behaviour:
- Reset (rstb low, async): state IDLE, all outputs 0, bit counter 0, valid 0.
- States: IDLE, ISSUE, WAIT, FIN.
- IDLE: start has priority over step.
  - start: latch gate_id, k=0, first=1, then ISSUE.
  - Else step with valid=1: latch step operands, first=0, step mode, then ISSUE.
  - step with valid=0: ignored, no done.
- ISSUE, one cycle:
  - mult_en=1; mult_restart=first.
  - Sequence mode: mult_gate_bit=gate_id_q[k], mult_tau=taus[k], mult_m_tau_p1=m_taus_p1[k].
  - Step mode: latched step values.
  - Then WAIT.
- Operand outputs are registered and held stable from ISSUE through end of WAIT. mult_en and mult_restart are high only in ISSUE.
- WAIT: on mult_ready_pulse, first<=0.
  - Sequence mode, k<NGATEBITS-1: k<=k+1, go to ISSUE.
  - Otherwise: result<=mult_result, go to FIN.
- FIN, one cycle: done=1, valid=1, return to IDLE.
- busy=1 in ISSUE/WAIT/FIN.
- Latency:
  - Initial sequence: done asserted NGATEBITS*(1+L)+1 cycles after the start cycle's next edge, where L is the multiplier cycles from en to ready_pulse.
  - Step: 1+L+1 cycles.
- start or step while busy: ignored, no queuing.
- A start while valid=1 clears valid on acceptance. The result register keeps its old value until the new FIN.
- mult_ready_pulse outside WAIT: ignored.
- NGATEBITS=1: single ISSUE with restart=1, then FIN.
- Reset mid-operation: immediate return to reset values. The multiplier slice is reset by the same rstb.

Optional Feature:
- PERGATE_SEQ_ABORT_EN, when defined:
  - Adds input abort (1 bit).
  - abort high in ISSUE or WAIT forces IDLE next cycle, with valid=0, no done, and result unchanged.
  - A pending mult_ready_pulse after an abort is ignored.
  - abort in IDLE or FIN has no effect.
- Undefined: port absent; every accepted sequence runs to completion.

Test Plan:
- Operands for all cases: NGATEBITS=3, taus={4,3,2} (k=2..0), m_taus_p1={7,6,5}.
- Basic sequence: start with gate_id=3'b101 -> mult_restart only on first ISSUE; three mult_en pulses; result=2*6*4=48; one done pulse; valid=1; busy low afterwards.
- Step after sequence: valid=1, step with step_bit=1, step_tau=10 -> exactly one mult_en with mult_restart=0; result=480; done pulse.
- Collision: start and step in the same IDLE cycle -> start wins; a start pulse asserted during WAIT is ignored; only one done.
- Step before any result: step after reset with valid=0 -> no mult_en, no done, result=0.
- Reset mid-WAIT: rstb low during the second WAIT -> all outputs 0 immediately; a fresh start with gate_id=3'b000 gives result=5*6*7=210.
- Abort (PERGATE_SEQ_ABORT_EN defined): abort during the second WAIT -> IDLE next cycle, valid=0, no done, result unchanged; a later ready_pulse is ignored.
